// File: rtl/gate_input_debouncer_pkg.sv
// Shared constants for the gate input conditioning slice.
package gate_pkg;
   localparam int DEFAULT_STABLE_CYCLES = 4;
   localparam int CLK_PERIOD            = 10;
   localparam int GATE_WIDTH            = 2;
endpackage

// File: rtl/gate_input_debouncer_if.sv
// Raw pin inputs and conditioned gate operands/events between stimulus and debouncer.
interface gate_input_debouncer_if
   import gate_pkg::*;
#(
   parameter int WIDTH = GATE_WIDTH
);
   logic [WIDTH-1:0] raw_in;
   logic [WIDTH-1:0] clean_out;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;

   modport master (output raw_in, input clean_out, rise, fall);
   modport slave  (input raw_in, output clean_out, rise, fall);
endinterface

// File: rtl/gate_input_debouncer_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter, clean level and edge pulses.
module debounce_channel
   import gate_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_clean,
   output logic o_rise,
   output logic o_fall
);
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   logic [CNT_W-1:0] r_cnt;
   logic             r_clean;
   logic             r_rise;
   logic             r_fall;
   logic             w_differ;
   logic             w_accept;

   assign w_differ = r_s2 ^ r_clean;
   assign w_accept = w_differ && (r_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
      end
   end

   // Any sample matching the current clean level restarts the window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_clean <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise <= w_accept & r_s2;
         r_fall <= w_accept & ~r_s2;
         if (!w_differ) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_clean <= r_s2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_clean = r_clean;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;
endmodule

// File: rtl/gate_input_debouncer.sv
// Debounces WIDTH raw inputs into clean gate operands with per-channel rise/fall events.
module gate_input_debouncer
   import gate_pkg::*;
#(
   parameter int WIDTH         = GATE_WIDTH,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input logic                   clk,
   input logic                   rst,
   gate_input_debouncer_if.slave bus
);
   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      debounce_channel #(
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .i_raw  (bus.raw_in[g]),
         .o_clean(bus.clean_out[g]),
         .o_rise (bus.rise[g]),
         .o_fall (bus.fall[g])
      );
   end
endmodule

// File: tb/tb_gate_input_debouncer.sv
// Directed + random bench for gate_input_debouncer against a window-based reference model.
module tb_gate_input_debouncer;
   import gate_pkg::*;

   localparam int W = 2;
   localparam int S = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   gate_input_debouncer_if #(.WIDTH(W)) bus ();

   gate_input_debouncer #(
      .WIDTH        (W),
      .STABLE_CYCLES(S)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #(CLK_PERIOD / 2) clk = ~clk;

   // Model: raw history per edge; each edge the filter sees the sample taken two edges
   // earlier, and a channel flips once its last S seen samples all oppose its clean level.
   logic [W-1:0] rawq[$];
   logic [W-1:0] seenq[$];
   logic [W-1:0] exp_clean;
   logic [W-1:0] exp_rise;
   logic [W-1:0] exp_fall;
   int           errors = 0;
   int           checks = 0;

   task automatic model_reset();
      rawq.delete();
      rawq.push_back('0);
      rawq.push_back('0);
      seenq.delete();
      exp_clean = '0;
      exp_rise  = '0;
      exp_fall  = '0;
   endtask

   task automatic model_edge(input logic [W-1:0] raw);
      logic [W-1:0] seen;
      logic [W-1:0] smp;
      bit           all_diff;
      rawq.push_back(raw);
      seen = rawq[rawq.size() - 3];
      seenq.push_back(seen);
      exp_rise = '0;
      exp_fall = '0;
      for (int i = 0; i < W; i++) begin
         if (seenq.size() >= S) begin
            all_diff = 1'b1;
            for (int j = 0; j < S; j++) begin
               smp = seenq[seenq.size() - 1 - j];
               if (smp[i] == exp_clean[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
               exp_clean[i] = ~exp_clean[i];
               if (exp_clean[i]) exp_rise[i] = 1'b1;
               else              exp_fall[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic check_outputs();
      checks++;
      assert (bus.clean_out === exp_clean) else begin
         errors++;
         $error("FAIL clean_out t=%0t got=%b exp=%b", $time, bus.clean_out, exp_clean);
      end
      checks++;
      assert (bus.rise === exp_rise) else begin
         errors++;
         $error("FAIL rise t=%0t got=%b exp=%b", $time, bus.rise, exp_rise);
      end
      checks++;
      assert (bus.fall === exp_fall) else begin
         errors++;
         $error("FAIL fall t=%0t got=%b exp=%b", $time, bus.fall, exp_fall);
      end
   endtask

   task automatic tick(input logic [W-1:0] raw);
      bus.raw_in = raw;
      @(posedge clk);
      if (!rst) model_edge(raw);
      #1;
      check_outputs();
   endtask

   task automatic reset_on();
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
   endtask

   // Ticks until clean_out[bit] reaches lvl; number of ticks must equal exp_n.
   task automatic latency(input string tag, input int b, input logic [W-1:0] raw,
                          input logic lvl, input int exp_n);
      int n;
      n = 0;
      do begin
         tick(raw);
         n++;
      end while (bus.clean_out[b] !== lvl && n < 20);
      checks++;
      assert (n === exp_n) else begin
         errors++;
         $error("FAIL %s latency got=%0d exp=%0d", tag, n, exp_n);
      end
   endtask

   initial begin
      logic [W-1:0] v;
      int           h;
      bus.raw_in = 2'b11;
      rst        = 1'b1;
      #1;
      model_reset();
      check_outputs();

      // Reset held with inputs high.
      repeat (4) tick(2'b11);
      rst = 1'b0;
      repeat (6) tick(2'b00);

      // Clean step on bit0: edge k sample, flip at edge k+S+1.
      latency("step0", 0, 2'b01, 1'b1, S + 2);
      repeat (3) tick(2'b01);

      // Short glitch on bit1 must be filtered.
      repeat (3) tick(2'b11);
      repeat (8) tick(2'b01);

      // Bouncing bit1 then steady high.
      tick(2'b11); tick(2'b01); tick(2'b11); tick(2'b11); tick(2'b01); tick(2'b11);
      repeat (8) tick(2'b11);

      // Both high until clean, then simultaneous drop.
      latency("both_hi", 1, 2'b11, 1'b1, 1);
      repeat (8) tick(2'b00);

      // Reset mid-count on a rising channel, released with input held high.
      repeat (4) tick(2'b01);
      reset_on();
      repeat (3) tick(2'b01);
      rst = 1'b0;
      latency("post_rst", 0, 2'b01, 1'b1, S + 2);
      repeat (4) tick(2'b01);

      // Random segments with random hold lengths and occasional resets.
      repeat (120) begin
         v = W'($urandom_range(0, 3));
         h = $urandom_range(1, 8);
         repeat (h) tick(v);
         if ($urandom_range(0, 24) == 0) begin
            reset_on();
            tick(v);
            rst = 1'b0;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
